// File: rtl/lap_memory_recall.sv
// Lap history: captures live BCD time into a DEPTH-entry ring and recalls laps onto the LED byte.
// Latency: control state updates 1 cycle after a button edge; LED is registered (edge -> LED in 2 cycles).
// Backpressure: none; buttons are edge-detected levels, a full ring overwrites its oldest record.
module lap_memory_recall #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK_50M,
    input  logic              reset,
    input  logic [15:0]       digits_in,
    input  logic              lap_strobe,
    input  logic              clear_laps,
    input  logic              recall_btn,
    input  logic              next_btn,
    input  logic              SW,
    output logic [7:0]        LED,
    output logic [ADDR_W:0]   lap_count,
    output logic              full,
    output logic              recall_active,
    output logic [ADDR_W-1:0] recall_index
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [3:0] deca;
        logic [3:0] unit;
        logic [3:0] deci;
        logic [3:0] centi;
    } lap_rec_t;

    typedef enum logic {
        LIVE   = 1'b0,
        RECALL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en;

    logic lap_q, clr_q, rcl_q, nxt_q;
    logic lap_ev, clr_ev, rcl_ev, nxt_ev;

    lap_rec_t          mem [DEPTH];
    lap_rec_t          rec;
    logic [ADDR_W-1:0] rd_addr;

    assign lap_ev = lap_strobe & ~lap_q;
    assign clr_ev = clear_laps & ~clr_q;
    assign rcl_ev = recall_btn & ~rcl_q;
    assign nxt_ev = next_btn   & ~nxt_q;

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            lap_q <= 1'b0;
            clr_q <= 1'b0;
            rcl_q <= 1'b0;
            nxt_q <= 1'b0;
        end else begin
            lap_q <= lap_strobe;
            clr_q <= clear_laps;
            rcl_q <= recall_btn;
            nxt_q <= next_btn;
        end
    end

    // Priority chain: only the highest-priority event of a cycle acts.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        if (clr_ev) begin
            state_d  = LIVE;
            wr_ptr_d = '0;
            idx_d    = '0;
            cnt_d    = '0;
        end else if (lap_ev) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            idx_d    = '0;
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (rcl_ev) begin
            case (state_q)
                LIVE: begin
                    if (cnt_q != '0) begin
                        state_d = RECALL;
                        idx_d   = '0;
                    end
                end
                RECALL: begin
                    state_d = LIVE;
                    idx_d   = '0;
                end
                default: state_d = LIVE;
            endcase
        end else if (nxt_ev && (state_q == RECALL)) begin
            if (({1'b0, idx_q} + CNT_W'(1)) == cnt_q) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state_q <= LIVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            wr_ptr_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr_q] <= lap_rec_t'(digits_in);
        end
    end

    // Newest record sits one behind the write pointer; recall_index walks further back.
    assign rd_addr = wr_ptr_q - ADDR_W'(1) - idx_q;
    assign rec     = mem[rd_addr];

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            LED <= '0;
        end else if (state_q == RECALL) begin
            LED <= SW ? {rec.deca, rec.unit} : {rec.deci, rec.centi};
        end else begin
            LED <= SW ? digits_in[15:8] : digits_in[7:0];
        end
    end

    assign lap_count     = cnt_q;
    assign full          = (cnt_q == CNT_FULL);
    assign recall_active = (state_q == RECALL);
    assign recall_index  = idx_q;

endmodule

// File: tb/tb_lap_memory_recall.sv
// Directed bench for lap_memory_recall: reset, live display, capture/recall, wrap, priority and reset override.
// Latency: inputs driven 1 ns after each rising edge, outputs sampled at the same point.
// Backpressure: none; all waits are fixed cycle counts.
module tb_lap_memory_recall;

    logic        CLK_50M;
    logic        reset;
    logic [15:0] digits_in;
    logic        lap_strobe;
    logic        clear_laps;
    logic        recall_btn;
    logic        next_btn;
    logic        SW;
    logic [7:0]  LED;
    logic [3:0]  lap_count;
    logic        full;
    logic        recall_active;
    logic [2:0]  recall_index;

    int vectors = 0;
    int errors  = 0;

    lap_memory_recall #(.DEPTH(8), .ADDR_W(3)) dut (
        .CLK_50M       (CLK_50M),
        .reset         (reset),
        .digits_in     (digits_in),
        .lap_strobe    (lap_strobe),
        .clear_laps    (clear_laps),
        .recall_btn    (recall_btn),
        .next_btn      (next_btn),
        .SW            (SW),
        .LED           (LED),
        .lap_count     (lap_count),
        .full          (full),
        .recall_active (recall_active),
        .recall_index  (recall_index)
    );

    initial CLK_50M = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    task automatic tick();
        @(posedge CLK_50M);
        #1;
    endtask

    // 0 lap, 1 clear, 2 recall, 3 next: one-cycle high then one cycle low.
    task automatic pulse(input int b);
        case (b)
            0: lap_strobe = 1'b1;
            1: clear_laps = 1'b1;
            2: recall_btn = 1'b1;
            default: next_btn = 1'b1;
        endcase
        tick();
        lap_strobe = 1'b0;
        clear_laps = 1'b0;
        recall_btn = 1'b0;
        next_btn   = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        digits_in = 16'h1234;
        SW = 1'b0;
        tick();
        tick();
        vectors++; if (LED !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", LED); end
        vectors++; if (lap_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", lap_count); end
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (recall_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", recall_active); end
        vectors++; if (recall_index !== 3'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", recall_index); end
        reset = 1'b0;
        tick();
        vectors++; if (LED !== 8'h34) begin errors++; $display("FAIL live_lo: got %h want 34", LED); end
        SW = 1'b1;
        tick();
        vectors++; if (LED !== 8'h12) begin errors++; $display("FAIL live_hi: got %h want 12", LED); end
        vectors++; if (lap_count !== 4'd0) begin errors++; $display("FAIL live_count: got %0d want 0", lap_count); end
        SW = 1'b0;
    endtask

    task automatic test_recall_basic();
        digits_in = 16'h0105; pulse(0);
        digits_in = 16'h0210; pulse(0);
        digits_in = 16'h0315; pulse(0);
        vectors++; if (lap_count !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", lap_count); end
        digits_in = 16'h9999;
        tick();
        recall_btn = 1'b1;
        tick();
        recall_btn = 1'b0;
        vectors++; if (recall_active !== 1'b1) begin errors++; $display("FAIL basic_active: got %b want 1", recall_active); end
        vectors++; if (LED !== 8'h99) begin errors++; $display("FAIL basic_led_lag: got %h want 99", LED); end
        tick();
        vectors++; if (LED !== 8'h15) begin errors++; $display("FAIL basic_led0: got %h want 15", LED); end
        vectors++; if (recall_index !== 3'd0) begin errors++; $display("FAIL basic_idx0: got %0d want 0", recall_index); end
        pulse(3);
        vectors++; if (LED !== 8'h10) begin errors++; $display("FAIL basic_led1: got %h want 10", LED); end
        vectors++; if (recall_index !== 3'd1) begin errors++; $display("FAIL basic_idx1: got %0d want 1", recall_index); end
        pulse(3);
        vectors++; if (LED !== 8'h05) begin errors++; $display("FAIL basic_led2: got %h want 05", LED); end
        vectors++; if (recall_index !== 3'd2) begin errors++; $display("FAIL basic_idx2: got %0d want 2", recall_index); end
        pulse(3);
        vectors++; if (LED !== 8'h15) begin errors++; $display("FAIL basic_wrap_led: got %h want 15", LED); end
        vectors++; if (recall_index !== 3'd0) begin errors++; $display("FAIL basic_wrap_idx: got %0d want 0", recall_index); end
        SW = 1'b1;
        tick();
        vectors++; if (LED !== 8'h03) begin errors++; $display("FAIL basic_hi_byte: got %h want 03", LED); end
        SW = 1'b0;
        pulse(2);
        vectors++; if (recall_active !== 1'b0) begin errors++; $display("FAIL basic_exit: got %b want 0", recall_active); end
        vectors++; if (LED !== 8'h99) begin errors++; $display("FAIL basic_exit_led: got %h want 99", LED); end
    endtask

    task automatic test_recall_empty();
        pulse(1);
        vectors++; if (lap_count !== 4'd0) begin errors++; $display("FAIL empty_count: got %0d want 0", lap_count); end
        digits_in = 16'h4321;
        pulse(2);
        vectors++; if (recall_active !== 1'b0) begin errors++; $display("FAIL empty_active: got %b want 0", recall_active); end
        vectors++; if (LED !== 8'h21) begin errors++; $display("FAIL empty_led: got %h want 21", LED); end
        digits_in = 16'h8765;
        tick();
        vectors++; if (LED !== 8'h65) begin errors++; $display("FAIL empty_follow: got %h want 65", LED); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_led;
        for (int i = 0; i < 10; i++) begin
            digits_in = 16'(i);
            pulse(0);
            if (i == 6) begin
                vectors++; if (lap_count !== 4'd7) begin errors++; $display("FAIL wrap_count7: got %0d want 7", lap_count); end
                vectors++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_notfull: got %b want 0", full); end
            end
        end
        vectors++; if (lap_count !== 4'd8) begin errors++; $display("FAIL wrap_count: got %0d want 8", lap_count); end
        vectors++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_full: got %b want 1", full); end
        digits_in = 16'hAAAA;
        pulse(2);
        for (int k = 0; k < 8; k++) begin
            exp_led = 8'(9 - k);
            vectors++; if (LED !== exp_led) begin errors++; $display("FAIL wrap_led%0d: got %h want %h", k, LED, exp_led); end
            vectors++; if (recall_index !== 3'(k)) begin errors++; $display("FAIL wrap_idx%0d: got %0d want %0d", k, recall_index, k); end
            pulse(3);
        end
        vectors++; if (LED !== 8'h09) begin errors++; $display("FAIL wrap_around_led: got %h want 09", LED); end
        vectors++; if (recall_index !== 3'd0) begin errors++; $display("FAIL wrap_around_idx: got %0d want 0", recall_index); end
    endtask

    task automatic test_capture_in_recall();
        pulse(3);
        pulse(3);
        vectors++; if (LED !== 8'h07) begin errors++; $display("FAIL cir_led_idx2: got %h want 07", LED); end
        digits_in = 16'h0777;
        pulse(0);
        vectors++; if (recall_index !== 3'd0) begin errors++; $display("FAIL cir_idx: got %0d want 0", recall_index); end
        vectors++; if (LED !== 8'h77) begin errors++; $display("FAIL cir_led: got %h want 77", LED); end
        vectors++; if (recall_active !== 1'b1) begin errors++; $display("FAIL cir_active: got %b want 1", recall_active); end
        digits_in = 16'h0555;
        clear_laps = 1'b1;
        lap_strobe = 1'b1;
        tick();
        clear_laps = 1'b0;
        lap_strobe = 1'b0;
        tick();
        vectors++; if (lap_count !== 4'd0) begin errors++; $display("FAIL prio_count: got %0d want 0", lap_count); end
        vectors++; if (recall_active !== 1'b0) begin errors++; $display("FAIL prio_active: got %b want 0", recall_active); end
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL prio_full: got %b want 0", full); end
        vectors++; if (LED !== 8'h55) begin errors++; $display("FAIL prio_led: got %h want 55", LED); end
    endtask

    task automatic test_back_to_back();
        digits_in = 16'h0123;
        pulse(0);
        digits_in = 16'h0246;
        lap_strobe = 1'b1;
        tick();
        tick();
        tick();
        lap_strobe = 1'b0;
        tick();
        vectors++; if (lap_count !== 4'd2) begin errors++; $display("FAIL held_count: got %0d want 2", lap_count); end
        digits_in = 16'h0369;
        pulse(0);
        vectors++; if (lap_count !== 4'd3) begin errors++; $display("FAIL rearm_count: got %0d want 3", lap_count); end
        digits_in = 16'h0000;
        pulse(2);
        vectors++; if (LED !== 8'h69) begin errors++; $display("FAIL b2b_led0: got %h want 69", LED); end
        pulse(3);
        vectors++; if (LED !== 8'h46) begin errors++; $display("FAIL b2b_led1: got %h want 46", LED); end
    endtask

    task automatic test_reset_mid();
        reset    = 1'b1;
        next_btn = 1'b1;
        tick();
        vectors++; if (LED !== 8'h00) begin errors++; $display("FAIL rmid_led: got %h want 00", LED); end
        vectors++; if (lap_count !== 4'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", lap_count); end
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL rmid_full: got %b want 0", full); end
        vectors++; if (recall_active !== 1'b0) begin errors++; $display("FAIL rmid_active: got %b want 0", recall_active); end
        vectors++; if (recall_index !== 3'd0) begin errors++; $display("FAIL rmid_index: got %0d want 0", recall_index); end
        reset    = 1'b0;
        next_btn = 1'b0;
        digits_in = 16'h0E0F;
        tick();
        pulse(0);
        vectors++; if (lap_count !== 4'd1) begin errors++; $display("FAIL rmid_cap_count: got %0d want 1", lap_count); end
        digits_in = 16'h1111;
        pulse(2);
        vectors++; if (LED !== 8'h0F) begin errors++; $display("FAIL rmid_cap_led: got %h want 0f", LED); end
        pulse(3);
        vectors++; if (recall_index !== 3'd0) begin errors++; $display("FAIL rmid_one_wrap: got %0d want 0", recall_index); end
    endtask

    initial begin
        reset      = 1'b1;
        digits_in  = 16'h0000;
        lap_strobe = 1'b0;
        clear_laps = 1'b0;
        recall_btn = 1'b0;
        next_btn   = 1'b0;
        SW         = 1'b0;
        test_reset();
        test_recall_basic();
        test_recall_empty();
        test_wrap();
        test_capture_in_recall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
